// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (1-cycle registered read)
// between two requesters, A and B.
//
// After reset the whole RAM (depth words) is cleared to zero, then per-cycle
// read/write commands are granted round-robin. Read data is steered back to
// the requester that issued the read by a 2-cycle tag pipeline.
//
// Ports:
//   clk, rst               clock (posedge) and synchronous active-high reset
//   init_done              high once the RAM clear has finished (sticky until rst)
//   a_req/a_we/a_addr/a_wdata  requester A command (held until a_gnt)
//   a_gnt                  A command accepted this cycle (combinational)
//   a_rdata/a_rvalid       A read data and its one-cycle valid pulse
//   b_*                    same as A, for requester B
//   ram_addr/ram_in/ram_we/ram_re  RAM command outputs
//   ram_out                RAM read data input
//
// Optional feature (macro RAM_ARB_STATS_EN): adds 16-bit saturating grant
// counters a_grant_cnt / b_grant_cnt, cleared on rst.

module ram_arbiter #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 5,
  parameter int unsigned depth      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [addr_width-1:0] a_addr,
  input  logic [data_width-1:0] a_wdata,
  output logic                  a_gnt,
  output logic [data_width-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [addr_width-1:0] b_addr,
  input  logic [data_width-1:0] b_wdata,
  output logic                  b_gnt,
  output logic [data_width-1:0] b_rdata,
  output logic                  b_rvalid,
`ifdef RAM_ARB_STATS_EN
  output logic [15:0]           a_grant_cnt,
  output logic [15:0]           b_grant_cnt,
`endif
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_in,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [data_width-1:0] ram_out
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic                  clear_last;
  logic                  run;

  // Round-robin pointer: 0 = A was last granted, 1 = B was last granted.
  logic                  rr_q;

  // Command register, presented to the RAM the cycle after the grant.
  logic                  cmd_valid_q;
  logic                  cmd_we_q;
  logic                  cmd_id_q;
  logic [addr_width-1:0] cmd_addr_q;
  logic [data_width-1:0] cmd_wdata_q;

  // Read tag: marks the cycle in which ram_out carries read data and for whom.
  logic                  rtag_valid_q;
  logic                  rtag_id_q;

  assign clear_last = (cnt_q == addr_width'(depth - 1));
  assign run        = (state_q == StRun) && !rst;

  // Next-state for the init/run sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (clear_last) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: state_d = StInit;
    endcase
  end

  // Arbitration: on a tie the requester not pointed to by rr wins.
  assign a_gnt = run & a_req & (~b_req | rr_q);
  assign b_gnt = run & b_req & (~a_req | ~rr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      rr_q         <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_id_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rtag_valid_q <= 1'b0;
      rtag_id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (a_gnt || b_gnt) begin
        cmd_valid_q <= 1'b1;
        cmd_we_q    <= a_gnt ? a_we : b_we;
        cmd_id_q    <= b_gnt;
        cmd_addr_q  <= a_gnt ? a_addr : b_addr;
        cmd_wdata_q <= a_gnt ? a_wdata : b_wdata;
        rr_q        <= b_gnt;
      end else begin
        cmd_valid_q <= 1'b0;
      end
      rtag_valid_q <= cmd_valid_q & ~cmd_we_q;
      rtag_id_q    <= cmd_id_q;
    end
  end

  // RAM drive. Outputs are forced quiet while rst is high, since the
  // registered state only reflects reset after the first edge.
  always_comb begin
    init_done = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_in    = '0;
    if (!rst) begin
      if (state_q == StInit) begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
      end else begin
        init_done = 1'b1;
        ram_we    = cmd_valid_q & cmd_we_q;
        ram_re    = cmd_valid_q & ~cmd_we_q;
        ram_addr  = cmd_addr_q;
        ram_in    = cmd_wdata_q;
      end
    end
  end

  // Both rdata ports mirror ram_out; only rvalid is qualified.
  assign a_rdata  = ram_out;
  assign b_rdata  = ram_out;
  assign a_rvalid = !rst & rtag_valid_q & ~rtag_id_q;
  assign b_rvalid = !rst & rtag_valid_q & rtag_id_q;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] a_cnt_q, b_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (a_gnt && (a_cnt_q != 16'hFFFF)) begin
        a_cnt_q <= a_cnt_q + 16'd1;
      end
      if (b_gnt && (b_cnt_q != 16'hFFFF)) begin
        b_cnt_q <= b_cnt_q + 16'd1;
      end
    end
  end

  assign a_grant_cnt = a_cnt_q;
  assign b_grant_cnt = b_cnt_q;
`endif

endmodule
